vga_out_stage: RTL

Registered VGA output stage between the renderer's 6-bit BBGGRR pixel/sync outputs and the 3-bit VGA pins. It blanks pixels outside the visible area and applies the 2-bit-per-channel ordered dither down to 1 bit per channel. It keeps hsync/vsync pipeline-aligned with the pixel data. It replaces the ad-hoc field toggle clocked by vsync_n with a field/frame counter in the clk domain.

---
 rtl/vga_out_stage_if.sv | 23 ++
 rtl/vga_out_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/vga_out_stage_if.sv
// Renderer-to-VGA-pin bundle for vga_out_stage: renderer sync/position/pixel in, registered VGA pins out.
// master = renderer side (drives pixel stream), slave = the output stage.
interface vga_out_stage_if;
  logic       hsync_n_in;
  logic       vsync_n_in;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic [5:0] rgb6;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic       field;

  modport master (
    output hsync_n_in, vsync_n_in, hpos, vpos, rgb6,
    input  hsync, vsync, rgb, field
  );

  modport slave (
    input  hsync_n_in, vsync_n_in, hpos, vpos, rgb6,
    output hsync, vsync, rgb, field
  );
endinterface

// File: rtl/vga_out_stage.sv
// Two-stage registered VGA output: blanking, sync inversion and optional 2x2 ordered dither of BBGGRR to 3-bit RGB.
// Define VGA_OUT_DITHER_EN to enable the dither and the clk-domain field/frame counter; otherwise field=0 and MSBs pass.
module vga_out_stage #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned FIELD_DIV = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  vga_out_stage_if.slave  vga
);

  localparam logic [9:0] H_LIM = 10'(H_VISIBLE);
  localparam logic [9:0] V_LIM = 10'(V_VISIBLE);

  // Stage 1
  logic s1_hsync_n_q;
  logic s1_vsync_n_q;
  logic s1_vis_q;
  logic s1_vis_d;

  // Stage 2
  logic       hsync_q;
  logic       vsync_q;
  logic [2:0] rgb_q;
  logic [2:0] rgb_d;

  assign s1_vis_d = (vga.hpos < H_LIM) && (vga.vpos < V_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_hsync_n_q <= 1'b1;
      s1_vsync_n_q <= 1'b1;
      s1_vis_q     <= 1'b0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      rgb_q        <= '0;
    end else begin
      s1_hsync_n_q <= vga.hsync_n_in;
      s1_vsync_n_q <= vga.vsync_n_in;
      s1_vis_q     <= s1_vis_d;
      hsync_q      <= ~s1_hsync_n_q;
      vsync_q      <= ~s1_vsync_n_q;
      rgb_q        <= rgb_d;
    end
  end

`ifdef VGA_OUT_DITHER_EN
  localparam int unsigned CNT_W = $clog2(FIELD_DIV) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIELD_DIV - 1);

  logic             s1_xo_q;
  logic             s1_yo_q;
  logic [5:0]       s1_rgb6_q;
  logic             vs_prev_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] frame_cnt_d;
  logic             field_q;
  logic             field_d;
  logic             vs_fall;
  logic             dither_hi;

  function automatic logic chan(input logic [1:0] lvl, input logic dh);
    case (lvl)
      2'b11:   return 1'b1;
      2'b10:   return dh;
      2'b01:   return ~dh;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_xo_q     <= 1'b0;
      s1_yo_q     <= 1'b0;
      s1_rgb6_q   <= '0;
      vs_prev_q   <= 1'b1;
      frame_cnt_q <= '0;
      field_q     <= 1'b0;
    end else begin
      s1_xo_q     <= vga.hpos[0];
      s1_yo_q     <= vga.vpos[0];
      s1_rgb6_q   <= vga.rgb6;
      vs_prev_q   <= vga.vsync_n_in;
      frame_cnt_q <= frame_cnt_d;
      field_q     <= field_d;
    end
  end

  // Field only advances on a vsync_n falling edge, so it is stable across the visible frame.
  always_comb begin
    vs_fall     = ~vga.vsync_n_in & vs_prev_q;
    frame_cnt_d = frame_cnt_q;
    field_d     = field_q;
    if (vs_fall) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_d = '0;
        field_d     = ~field_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    dither_hi = s1_yo_q ? (field_q | ~s1_xo_q) : (field_q ^ s1_xo_q);
    rgb_d     = '0;
    if (s1_vis_q) begin
      rgb_d[0] = chan(s1_rgb6_q[1:0], dither_hi);
      rgb_d[1] = chan(s1_rgb6_q[3:2], dither_hi);
      rgb_d[2] = chan(s1_rgb6_q[5:4], dither_hi);
    end
  end

  assign vga.field = field_q;
`else
  logic [2:0] s1_msb_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_msb_q <= '0;
    end else begin
      s1_msb_q <= {vga.rgb6[5], vga.rgb6[3], vga.rgb6[1]};
    end
  end

  always_comb begin
    rgb_d = s1_vis_q ? s1_msb_q : '0;
  end

  assign vga.field = 1'b0;
`endif

  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
  assign vga.rgb   = rgb_q;

endmodule
